// File: rtl/bp_mini_tlb_pkg.sv
// Shared types and sizing for the mini TLB and its replacement helper.
package bp_mini_tlb_pkg;

  localparam int unsigned mini_tlb_els_lp        = 8;
  localparam int unsigned mini_tlb_vtag_width_lp = 27;
  localparam int unsigned mini_tlb_ptag_width_lp = 28;
  localparam int unsigned mini_tlb_ptr_width_lp  = $clog2(mini_tlb_els_lp);

  typedef struct packed {
    logic                              v;
    logic [mini_tlb_vtag_width_lp-1:0] vtag;
    logic [mini_tlb_ptag_width_lp-1:0] ptag;
  } bp_mini_tlb_entry_s;

endpackage

// File: rtl/bp_mini_tlb_repl.sv
// Fill-slot selection: existing match, else lowest invalid, else round-robin victim.
module bp_mini_tlb_repl
  import bp_mini_tlb_pkg::*;
#(
  parameter int unsigned els_p = mini_tlb_els_lp,
  localparam int unsigned ptr_width_lp = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic [els_p-1:0]        valid_i,
  input  logic [els_p-1:0]        match_i,
  input  logic                    fill_i,
  output logic [ptr_width_lp-1:0] idx_o
);

  logic [ptr_width_lp-1:0] r_ptr;
  logic [ptr_width_lp-1:0] w_match_idx;
  logic [ptr_width_lp-1:0] w_inv_idx;
  logic                    w_any_match;
  logic                    w_any_inv;
  logic                    w_advance;

  always_comb begin
    w_match_idx = '0;
    w_inv_idx   = '0;
    w_any_inv   = 1'b0;
    for (int i = 0; i < int'(els_p); i++) begin
      if (match_i[i]) w_match_idx = ptr_width_lp'(i);
    end
    // Descending scan so the lowest invalid index wins.
    for (int i = int'(els_p) - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        w_inv_idx = ptr_width_lp'(i);
        w_any_inv = 1'b1;
      end
    end
  end

  assign w_any_match = |match_i;
  assign w_advance   = fill_i & ~w_any_match & ~w_any_inv;

  always_comb begin
    if (w_any_match)    idx_o = w_match_idx;
    else if (w_any_inv) idx_o = w_inv_idx;
    else                idx_o = r_ptr;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) r_ptr <= '0;
    else if (w_advance)     r_ptr <= r_ptr + 1'b1;
  end

endmodule

// File: rtl/bp_mini_tlb.sv
// Fully-associative vtag->ptag cache with a registered lookup port and one fill port.
module bp_mini_tlb
  import bp_mini_tlb_pkg::*;
#(
  parameter int unsigned els_p        = mini_tlb_els_lp,
  parameter int unsigned vtag_width_p = mini_tlb_vtag_width_lp,
  parameter int unsigned ptag_width_p = mini_tlb_ptag_width_lp
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    trans_en_i,
  input  logic                    r_v_i,
  input  logic [vtag_width_p-1:0] r_vtag_i,
  input  logic                    w_v_i,
  input  logic [vtag_width_p-1:0] w_vtag_i,
  input  logic [ptag_width_p-1:0] w_ptag_i,
  output logic                    r_v_o,
  output logic                    r_hit_o,
  output logic                    r_miss_o,
  output logic [ptag_width_p-1:0] r_ptag_o
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);
  localparam int unsigned copy_width_lp =
      (vtag_width_p < ptag_width_p) ? vtag_width_p : ptag_width_p;

  bp_mini_tlb_entry_s r_entries [els_p];

  logic                    r_out_v;
  logic                    r_out_hit;
  logic [ptag_width_p-1:0] r_out_ptag;

  logic [els_p-1:0]        w_valid;
  logic [els_p-1:0]        w_r_match;
  logic [els_p-1:0]        w_w_match;
  logic [ptag_width_p-1:0] w_cam_ptag;
  logic [ptag_width_p-1:0] w_pass_ptag;
  logic [ptag_width_p-1:0] w_ptag;
  logic                    w_hit;
  logic                    w_fill;
  logic [ptr_width_lp-1:0] w_fill_idx;

  // Match vectors are one-hot at most, so the ptag mux is a plain OR-reduce.
  always_comb begin
    w_cam_ptag = '0;
    for (int i = 0; i < int'(els_p); i++) begin
      w_valid[i]   = r_entries[i].v;
      w_r_match[i] = r_entries[i].v && (r_entries[i].vtag == r_vtag_i);
      w_w_match[i] = r_entries[i].v && (r_entries[i].vtag == w_vtag_i);
      if (w_r_match[i]) w_cam_ptag = w_cam_ptag | r_entries[i].ptag;
    end
  end

  always_comb begin
    w_pass_ptag = '0;
    w_pass_ptag[copy_width_lp-1:0] = r_vtag_i[copy_width_lp-1:0];
  end

  assign w_hit  = ~trans_en_i | (~flush_i & |w_r_match);
  assign w_ptag = trans_en_i ? w_cam_ptag : w_pass_ptag;
  assign w_fill = w_v_i & ~flush_i;

  bp_mini_tlb_repl #(
    .els_p (els_p)
  ) u_repl (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .valid_i (w_valid),
    .match_i (w_w_match),
    .fill_i  (w_fill),
    .idx_o   (w_fill_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      for (int i = 0; i < int'(els_p); i++) r_entries[i].v <= 1'b0;
    end else if (w_fill) begin
      r_entries[w_fill_idx] <= '{v: 1'b1, vtag: w_vtag_i, ptag: w_ptag_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_v    <= 1'b0;
      r_out_hit  <= 1'b0;
      r_out_ptag <= '0;
    end else begin
      r_out_v    <= r_v_i;
      r_out_hit  <= r_v_i & w_hit;
      r_out_ptag <= (r_v_i & w_hit) ? w_ptag : '0;
    end
  end

  assign r_v_o    = r_out_v;
  assign r_hit_o  = r_out_hit;
  assign r_miss_o = r_out_v & ~r_out_hit;
  assign r_ptag_o = r_out_ptag;

endmodule

// File: tb/tb_bp_mini_tlb.sv
// Scoreboard bench for bp_mini_tlb: directed scenarios, then randomized traffic.
module tb_bp_mini_tlb;

  localparam int ELS = 8;
  localparam int VW  = 27;
  localparam int PW  = 28;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          trans_en_i = 1'b1;
  logic          r_v_i = 1'b0;
  logic [VW-1:0] r_vtag_i = '0;
  logic          w_v_i = 1'b0;
  logic [VW-1:0] w_vtag_i = '0;
  logic [PW-1:0] w_ptag_i = '0;
  logic          r_v_o;
  logic          r_hit_o;
  logic          r_miss_o;
  logic [PW-1:0] r_ptag_o;

  bp_mini_tlb u_dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .flush_i    (flush_i),
    .trans_en_i (trans_en_i),
    .r_v_i      (r_v_i),
    .r_vtag_i   (r_vtag_i),
    .w_v_i      (w_v_i),
    .w_vtag_i   (w_vtag_i),
    .w_ptag_i   (w_ptag_i),
    .r_v_o      (r_v_o),
    .r_hit_o    (r_hit_o),
    .r_miss_o   (r_miss_o),
    .r_ptag_o   (r_ptag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hit;
    logic [PW-1:0] ptag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;

  // Reference model: a table of (valid, vtag, ptag) plus the round-robin victim index.
  bit            m_v  [ELS];
  logic [VW-1:0] m_vt [ELS];
  logic [PW-1:0] m_pt [ELS];
  int            m_ptr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("idle_r_v_o", 64'(r_v_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("r_v_o", 64'(r_v_o), 64'd1);
        chk("r_hit_o", 64'(r_hit_o), 64'(e.hit));
        chk("r_miss_o", 64'(r_miss_o), 64'(!e.hit));
        chk("r_ptag_o", 64'(r_ptag_o), 64'(e.ptag));
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < ELS; i++) m_v[i] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic model_fill(input logic [VW-1:0] vt, input logic [PW-1:0] pt);
    int slot = -1;
    for (int i = 0; i < ELS; i++) if (m_v[i] && m_vt[i] == vt) slot = i;
    if (slot < 0) begin
      for (int i = ELS - 1; i >= 0; i--) if (!m_v[i]) slot = i;
    end
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % ELS;
    end
    m_v[slot]  = 1'b1;
    m_vt[slot] = vt;
    m_pt[slot] = pt;
  endtask

  task automatic step(input bit rst, input bit fl, input bit te, input bit rv,
                      input logic [VW-1:0] rvt, input bit wv,
                      input logic [VW-1:0] wvt, input logic [PW-1:0] wpt);
    exp_t e;
    @(negedge clk);
    #1;
    reset_i = rst; flush_i = fl; trans_en_i = te;
    r_v_i = rv; r_vtag_i = rvt; w_v_i = wv; w_vtag_i = wvt; w_ptag_i = wpt;
    if (rv && !rst) begin
      e.hit  = 1'b0;
      e.ptag = '0;
      if (!te) begin
        e.hit  = 1'b1;
        e.ptag = PW'(rvt);
      end else if (!fl) begin
        for (int i = 0; i < ELS; i++) begin
          if (m_v[i] && m_vt[i] == rvt) begin
            e.hit  = 1'b1;
            e.ptag = m_pt[i];
          end
        end
      end
      exp_q.push_back(e);
    end
    if (rst || fl) model_clear();
    else if (wv) model_fill(wvt, wpt);
  endtask

  task automatic lookup(input logic [VW-1:0] vt, input bit te);
    step(0, 0, te, 1, vt, 0, '0, '0);
  endtask

  task automatic fill(input logic [VW-1:0] vt, input logic [PW-1:0] pt);
    step(0, 0, 1, 0, '0, 1, vt, pt);
  endtask

  task automatic idle();
    step(0, 0, 1, 0, '0, 0, '0, '0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_r_v_o", 64'(r_v_o), 64'd0);
    chk("reset_r_hit_o", 64'(r_hit_o), 64'd0);
    chk("reset_r_miss_o", 64'(r_miss_o), 64'd0);
    chk("reset_r_ptag_o", 64'(r_ptag_o), 64'd0);
    mon_en = 1'b1;

    // Cold miss, then fill and hit.
    lookup(27'h123, 1);
    fill(27'h123, 28'h8000123);
    lookup(27'h123, 1);

    // Nine distinct fills into eight entries from an empty table.
    step(0, 1, 1, 0, '0, 0, '0, '0);
    for (int i = 0; i < 9; i++) fill(VW'(27'h10 + i), PW'(28'h100 + i));
    for (int i = 0; i < 9; i++) lookup(VW'(27'h10 + i), 1);
    // Pointer now at 1: the next new vtag must evict 0x11.
    fill(27'h19, 28'h119);
    lookup(27'h11, 1);
    lookup(27'h12, 1);
    lookup(27'h19, 1);

    // Refill of an existing vtag overwrites in place.
    fill(27'h20, 28'hA);
    fill(27'h20, 28'hB);
    lookup(27'h20, 1);
    for (int i = 0; i < 8; i++) lookup(VW'(27'h12 + i), 1);

    // Same-cycle fill and lookup sees pre-fill contents.
    step(0, 0, 1, 1, 27'h30, 1, 27'h30, 28'hC);
    lookup(27'h30, 1);

    // Flush with concurrent fill and lookup.
    step(0, 1, 1, 1, 27'h30, 1, 27'h40, 28'hD);
    lookup(27'h40, 1);
    lookup(27'h30, 1);
    lookup(27'h123, 1);
    lookup(27'h40, 0);
    step(0, 1, 0, 1, 27'h7FFFFFF, 0, '0, '0);

    // Reset with a lookup in flight: the lookup is dropped and the table empties.
    fill(27'h50, 28'h55);
    step(0, 0, 1, 1, 27'h50, 0, '0, '0);
    step(1, 0, 1, 1, 27'h50, 1, 27'h51, 28'h66);
    lookup(27'h50, 1);
    lookup(27'h51, 1);

    for (int n = 0; n < 500; n++) begin
      bit            rst = ($urandom_range(0, 99) == 0);
      bit            fl  = ($urandom_range(0, 99) < 3);
      bit            te  = ($urandom_range(0, 9) != 0);
      bit            rv  = ($urandom_range(0, 9) < 7);
      bit            wv  = ($urandom_range(0, 9) < 4);
      logic [VW-1:0] rvt = VW'($urandom_range(0, 11));
      logic [VW-1:0] wvt = VW'($urandom_range(0, 11));
      logic [PW-1:0] wpt = PW'($urandom());
      step(rst, fl, te, rv, rvt, wv, wvt, wpt);
    end

    idle();
    idle();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
